// File: rtl/fp_mul_pkg.sv
// Shared binary32 constants, operand classes and classification helper for fp_mul.
package fp_mul_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int SIG_W    = FRAC_W + 1;
  localparam int PROD_W   = 2 * SIG_W;
  localparam int XEXP_W   = 10;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp_class_e;

  // Subnormals fold into ZERO so the datapath never sees a denormal significand.
  function automatic fp_class_e classify(input logic [EXP_W-1:0] exp_f,
                                         input logic [FRAC_W-1:0] frac_f);
    fp_class_e cls;
    if (exp_f == 8'h00) begin
      cls = ZERO;
    end else if (exp_f == 8'hFF) begin
      if (frac_f == 23'd0) begin
        cls = INF;
      end else begin
        cls = NAN;
      end
    end else begin
      cls = NORMAL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp_mul_core.sv
// Combinational binary32 multiply: classify, 24x24 significand product,
// normalize, round-to-nearest-even, and range/special-value selection.
module fp_mul_core
  import fp_mul_pkg::*;
(
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] product
);

  localparam logic signed [XEXP_W-1:0] BIAS_X  = 10'sd127;
  localparam logic signed [XEXP_W-1:0] EXP_MAX = 10'sd255;
  localparam logic signed [XEXP_W-1:0] EXP_MIN = 10'sd0;

  fp_class_e                  cls_a_s;
  fp_class_e                  cls_b_s;
  logic                       sign_s;
  logic [SIG_W-1:0]           sig_a_s;
  logic [SIG_W-1:0]           sig_b_s;
  logic [PROD_W-1:0]          prod_s;
  logic signed [XEXP_W-1:0]   exp_sum_s;
  logic signed [XEXP_W-1:0]   exp_norm_s;
  logic signed [XEXP_W-1:0]   exp_fin_s;
  logic [SIG_W-1:0]           mant_norm_s;
  logic                       guard_s;
  logic                       round_s;
  logic                       sticky_s;
  logic                       round_up_s;
  logic [SIG_W:0]             mant_rnd_s;
  logic [FRAC_W-1:0]          frac_fin_s;

  assign cls_a_s = classify(in1[30:23], in1[22:0]);
  assign cls_b_s = classify(in2[30:23], in2[22:0]);
  assign sign_s  = in1[31] ^ in2[31];

  assign sig_a_s = {1'b1, in1[22:0]};
  assign sig_b_s = {1'b1, in2[22:0]};
  assign prod_s  = {24'd0, sig_a_s} * {24'd0, sig_b_s};

  assign exp_sum_s = $signed({2'b00, in1[30:23]}) + $signed({2'b00, in2[30:23]}) - BIAS_X;

  // Normalize: product of two [1,2) significands lies in [1,4); bit47 means >= 2.
  always_comb begin
    mant_norm_s = 24'd0;
    guard_s     = 1'b0;
    round_s     = 1'b0;
    sticky_s    = 1'b0;
    exp_norm_s  = exp_sum_s;
    if (prod_s[47]) begin
      mant_norm_s = prod_s[47:24];
      guard_s     = prod_s[23];
      round_s     = prod_s[22];
      sticky_s    = |prod_s[21:0];
      exp_norm_s  = exp_sum_s + 10'sd1;
    end else begin
      mant_norm_s = prod_s[46:23];
      guard_s     = prod_s[22];
      round_s     = prod_s[21];
      sticky_s    = |prod_s[20:0];
      exp_norm_s  = exp_sum_s;
    end
  end

  // Round to nearest even; a carry out of the significand renormalizes once more.
  always_comb begin
    round_up_s = guard_s & (round_s | sticky_s | mant_norm_s[0]);
    mant_rnd_s = {1'b0, mant_norm_s} + {24'd0, round_up_s};
    frac_fin_s = 23'd0;
    exp_fin_s  = exp_norm_s;
    if (mant_rnd_s[24]) begin
      frac_fin_s = mant_rnd_s[23:1];
      exp_fin_s  = exp_norm_s + 10'sd1;
    end else begin
      frac_fin_s = mant_rnd_s[22:0];
      exp_fin_s  = exp_norm_s;
    end
  end

  // Special operands take precedence, then overflow to Inf and flush-to-zero.
  always_comb begin
    product = QNAN;
    if ((cls_a_s == NAN) || (cls_b_s == NAN)) begin
      product = QNAN;
    end else if (((cls_a_s == INF) && (cls_b_s == ZERO)) ||
                 ((cls_a_s == ZERO) && (cls_b_s == INF))) begin
      product = QNAN;
    end else if ((cls_a_s == INF) || (cls_b_s == INF)) begin
      product = {sign_s, POS_INF[30:0]};
    end else if ((cls_a_s == ZERO) || (cls_b_s == ZERO)) begin
      product = {sign_s, 31'd0};
    end else if (exp_fin_s >= EXP_MAX) begin
      product = {sign_s, POS_INF[30:0]};
    end else if (exp_fin_s <= EXP_MIN) begin
      product = {sign_s, 31'd0};
    end else begin
      product = {sign_s, exp_fin_s[7:0], frac_fin_s};
    end
  end

endmodule

// File: rtl/fp_mul.sv
// Single-cycle binary32 multiplier: registers the combinational core result
// and a one-cycle out_valid strobe per accepted operand pair.
module fp_mul
  import fp_mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out,
  output logic        out_valid
);

  logic [31:0] product_s;

  fp_mul_core u_core (
    .in1     (in1),
    .in2     (in2),
    .product (product_s)
  );

  // Output register: reset wins over in_valid; out holds when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= 32'h0000_0000;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out       <= product_s;
      out_valid <= 1'b1;
    end else begin
      out       <= out;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_mul.sv
// Randomized scoreboard bench for fp_mul against an integer-arithmetic binary32 model.
module tb_fp_mul;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] out;
  logic        out_valid;

  logic        rst_q = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] hold_val = 32'h0000_0000;
  int          n_vec = 0;
  int          n_err = 0;

  fp_mul dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .out       (out),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rst_q <= rst_n;

  // Reference: exact integer product, then generic RNE to 24 significant bits.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic             s;
    int               ea, eb, k, sh, e;
    longint unsigned  fa, fb, p, q, rem, half;
    bit               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0]      r;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    a_nan  = (ea == 255) && (fa != 0);
    b_nan  = (eb == 255) && (fb != 0);
    a_inf  = (ea == 255) && (fa == 0);
    b_inf  = (eb == 255) && (fb == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
    if (a_inf || b_inf) return {s, 31'h7F80_0000};
    if (a_zero || b_zero) return {s, 31'd0};
    p = (fa + 64'd8388608) * (fb + 64'd8388608);
    k = 47;
    while (((p >> k) & 64'd1) == 64'd0) k--;
    sh   = k - 23;
    q    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if ((rem > half) || ((rem == half) && (q[0] == 1'b1))) q = q + 64'd1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      k = k + 1;
    end
    e = ea + eb - 127 + (k - 46);
    if (e >= 255) return {s, 31'h7F80_0000};
    if (e <= 0) return {s, 31'd0};
    r = {s, e[7:0], q[22:0]};
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    int          sel;
    sel = int'($urandom_range(0, 9));
    f   = 23'($urandom);
    case (sel)
      0: begin e = 8'd0;   if ($urandom_range(0, 1) == 0) f = 23'd0; end
      1: begin e = 8'd255; if ($urandom_range(0, 1) == 0) f = 23'd0; end
      2, 3: e = 8'($urandom_range(107, 147));
      4: e = 8'($urandom_range(190, 254));
      5: e = 8'($urandom_range(1, 64));
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), e, f};
  endfunction

  task automatic drive_now(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    in_valid = 1'b1;
    in1      = a;
    in2      = b;
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    @(posedge clk);
    #1;
    drive_now(a, b, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in1      = 32'($urandom);
      in2      = 32'($urandom);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d products still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: reset state, in-order scoreboard pops, and output hold when idle.
  initial begin
    forever begin
      @(negedge clk);
      n_vec++;
      if (!rst_q) begin
        hold_val = 32'h0000_0000;
        if ((out !== 32'h0000_0000) || (out_valid !== 1'b0)) begin
          n_err++;
          $display("FAIL reset_state: out=%08h out_valid=%b, required out=00000000 out_valid=0",
                   out, out_valid);
        end
      end else if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_valid: out=%08h with no pending product", out);
        end else begin
          hold_val = exp_q.pop_front();
          if (out !== hold_val) begin
            n_err++;
            $display("FAIL product: got %08h, required %08h", out, hold_val);
          end
        end
      end else if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL out_valid_x: out_valid=%b, required 0 or 1", out_valid);
      end else if (out !== hold_val) begin
        n_err++;
        $display("FAIL hold: out=%08h, required held value %08h", out, hold_val);
      end
    end
  end

  localparam int ND = 15;
  logic [31:0] dir_a[ND] = '{32'h4000_0000, 32'h40A8_0000, 32'hBF80_0000, 32'h4020_0000,
                             32'h44FC_7333, 32'h44FC_7333, 32'h7F80_0000, 32'hFF80_0000,
                             32'hFF80_0000, 32'h0000_0000, 32'h7F00_0000, 32'h0080_0000,
                             32'h0000_0001, 32'h7FC0_1234, 32'h8000_0000};
  logic [31:0] dir_b[ND] = '{32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h4060_0000,
                             32'hC060_0000, 32'hFF80_0001, 32'h0000_0000, 32'h7F80_0000,
                             32'hFF80_0000, 32'h0000_0000, 32'h4000_0000, 32'h3F00_0000,
                             32'h7F00_0000, 32'h3F80_0000, 32'h4000_0000};
  logic [31:0] dir_e[ND] = '{32'h4000_0000, 32'h4128_0000, 32'hC000_0000, 32'h410C_0000,
                             32'hC5DC_E4CD, 32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000,
                             32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h0000_0000,
                             32'h0000_0000, 32'h7FC0_0000, 32'h8000_0000};

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in1      = 32'd0;
    in2      = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < ND; i++) apply(dir_a[i], dir_b[i], dir_e[i]);
    idle(2);
    apply(32'h3D82_0817, 32'h352E_B9ED, ref_mul(32'h3D82_0817, 32'h352E_B9ED));
    apply(32'h2F7F_D6D1, 32'hAE36_2451, ref_mul(32'h2F7F_D6D1, 32'hAE36_2451));
    idle(3);
    drain();

    // Reset with in_valid high, then back-to-back accepts from the first released edge.
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in1      = 32'h4000_0000;
    in2      = 32'h4040_0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_now(32'h3F80_0000, 32'h4040_0000, 32'h4040_0000);
    apply(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    apply(32'hC080_0000, 32'h3F00_0000, 32'hC000_0000);
    apply(32'h4100_0000, 32'h4100_0000, 32'h4280_0000);
    idle(3);
    drain();

    for (int i = 0; i < 400; i++) begin
      a = rand_op();
      b = rand_op();
      apply(a, b, ref_mul(a, b));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(3);
    drain();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_mul.md
FP_MUL -- requirements
Module: fp_mul

Interface
REQ-001 SHALL have no parameters; the block is fixed to IEEE-754 binary32.
REQ-002 SHALL provide a single clock and a synchronous, active-low reset: clk and rst_n.
REQ-003 SHALL have `clk`: input, 1 bit; rising-edge clock for all state.
REQ-004 SHALL have `rst_n`: input, 1 bit; synchronous, active-low reset.
REQ-005 SHALL have `in_valid`: input, 1 bit; when high, in1 and in2 are sampled this edge.
REQ-006 SHALL have `in1`: input, 32 bits; binary32 operand A (bit31 sign, 30:23 exponent, 22:0 fraction).
REQ-007 SHALL have `in2`: input, 32 bits; binary32 operand B, same layout as in1.
REQ-008 SHALL have `out`: output, 32 bits; registered binary32 product.
REQ-009 SHALL have `out_valid`: output, 1 bit; high for one cycle when out holds a new product.

Function
REQ-010 SHALL take in1/in2 on a rising clk edge with in_valid=1, and register out and out_valid=1 at that same edge (latency 1 cycle, throughput 1 per cycle).
REQ-011 SHALL hold out at its last value and drive out_valid=0 on any edge with in_valid=0.
REQ-012 SHALL compute the result sign as in1[31] XOR in2[31] for all non-NaN results.
REQ-013 SHALL treat subnormal inputs (exponent 0, fraction != 0) as signed zero (DAZ).
REQ-014 SHALL return canonical quiet NaN 0x7FC00000 if either input is NaN (exponent 0xFF, fraction != 0, quiet or signalling), or for Inf x 0 in either order.
REQ-015 SHALL return signed Inf (exponent 0xFF, fraction 0) for Inf x Inf, or Inf x nonzero finite.
REQ-016 SHALL return signed zero for zero x finite.
REQ-017 SHALL, for finite normal operands, multiply the 24-bit significands (hidden 1 restored) into a 48-bit product.
REQ-018 SHALL form the exponent as eA+eB-127, with at least 10-bit signed width so overflow and underflow are detectable.
REQ-019 SHALL normalize the product: if product bit47 is set, shift right by 1 and increment the exponent.
REQ-020 SHALL round to nearest, ties to even, using guard, round and sticky bits (sticky = OR of all lower bits).
REQ-021 SHALL, if rounding carries out of the significand, shift right by 1 and increment the exponent.
REQ-022 SHALL return signed Inf when the final biased exponent is >= 255 (overflow).
REQ-023 SHALL flush to signed zero when the final biased exponent is <= 0 (FTZ; no subnormal outputs).
REQ-024 SHALL never produce NaN with a non-canonical payload.

Reset
REQ-025 SHALL, on a rising edge with rst_n=0, set out=0x00000000 and out_valid=0.
REQ-026 SHALL give rst_n=0 priority over in_valid; an operation in flight during reset is discarded and produces no out_valid.
REQ-027 SHALL accept a new operation on the first edge with rst_n=1.

Structure
REQ-028 SHALL take from a shared package fp_mul_pkg: EXP_BIAS=127, EXP_W=8, FRAC_W=23, QNAN=0x7FC00000, POS_INF=0x7F800000, and the classification enum {ZERO, NORMAL, INF, NAN}.
REQ-029 SHALL place classification, the multiplier, normalization and rounding in a purely combinational sub-module fp_mul_core (in1, in2 -> product).
REQ-030 SHALL keep only the output registers and valid logic in fp_mul.

Verification
REQ-031 SHALL cover normal products, one cycle after in_valid:
- 0x40000000 x 0x3F800000 -> 0x40000000.
- 0x40A80000 x 0x40000000 -> 0x41280000.
- 0xBF800000 x 0x40000000 -> 0xC0000000.
- 0x40200000 x 0x40600000 -> 0x410C0000.
REQ-032 SHALL cover rounding: 0x44FC7333 (2019.6) x 0xC0600000 (-3.5) -> 0xC5DCE4CD.
REQ-033 SHALL cover special values:
- 0x44FC7333 x 0xFF800001 -> 0x7FC00000.
- 0x7F800000 x 0x00000000 -> 0x7FC00000.
- 0xFF800000 x 0x7F800000 -> 0xFF800000.
- 0xFF800000 x 0xFF800000 -> 0x7F800000.
- 0x00000000 x 0x00000000 -> 0x00000000.
REQ-034 SHALL cover range limits:
- 0x7F000000 x 0x40000000 -> 0x7F800000 (overflow).
- 0x00800000 x 0x3F000000 -> 0x00000000 (FTZ).
- 0x00000001 x 0x7F000000 -> 0x00000000 (DAZ).
REQ-035 SHALL cover reset: drive rst_n=0 with in_valid=1 -> out=0x00000000 and out_valid=0 on the next edge, then back-to-back in_valid for 4 cycles -> 4 consecutive out_valid pulses, each one cycle late and in order.
REQ-036 SHALL cover tiny normals: 0x3D820817 x 0x352EB9ED and 0x2F7FD6D1 x 0xAE362451 must match a bit-exact reference model (round to nearest even).
